// File: rtl/mux2_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux2_share_arbiter
// Purpose  : Round-robin owner of a shared 2:1 byte mux feeding a 1-entry
//            valid/ready output stage. Optional MUX2_ARB_LOCK_EN adds LOCK.
// Revision : 1.0 - initial release
// ============================================================================
module mux2_share_arbiter #(
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REQ0,
  input  logic [WIDTH-1:0] DIN0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] DIN1,
`ifdef MUX2_ARB_LOCK_EN
  input  logic             LOCK,
`endif
  input  logic             DREADY,
  output logic             GNT0,
  output logic             GNT1,
  output logic             ACK0,
  output logic             ACK1,
  output logic             SEL,
  output logic [WIDTH-1:0] DOUT,
  output logic             DVALID
);

  // State bits are the grant flops themselves: bit0 = GNT0, bit1 = GNT1.
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_OWN0 = 2'b01;
  localparam logic [1:0] S_OWN1 = 2'b10;
  localparam logic [4:0] C_HOLD = 5'(HOLD_MAX);

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dvalid_q, dvalid_d;

  logic             w_slot_free;
  logic             w_ack0, w_ack1;
  logic             w_lock;
  logic [4:0]       w_cnt_inc;
  logic             w_at_limit;

`ifdef MUX2_ARB_LOCK_EN
  assign w_lock = LOCK;
`else
  assign w_lock = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      cnt_q    <= 4'd0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

  // Limit test uses >= so a counter parked at HOLD_MAX by LOCK rotates on the next beat.
  assign w_cnt_inc  = {1'b0, cnt_q} + 5'd1;
  assign w_at_limit = (w_cnt_inc >= C_HOLD);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (REQ0 && (!REQ1 || last_q)) begin
          state_d = S_OWN0;
          last_d  = 1'b0;
          cnt_d   = 4'd0;
        end else if (REQ1) begin
          state_d = S_OWN1;
          last_d  = 1'b1;
          cnt_d   = 4'd0;
        end
      end
      S_OWN0: begin
        if (!REQ0) begin
          state_d = REQ1 ? S_OWN1 : S_IDLE;
          last_d  = REQ1 ? 1'b1 : last_q;
          cnt_d   = 4'd0;
        end else if (w_ack0) begin
          if (w_lock) begin
            cnt_d = w_at_limit ? C_HOLD[3:0] : w_cnt_inc[3:0];
          end else if (w_at_limit) begin
            cnt_d = 4'd0;
            if (REQ1) begin
              state_d = S_OWN1;
              last_d  = 1'b1;
            end
          end else begin
            cnt_d = w_cnt_inc[3:0];
          end
        end
      end
      S_OWN1: begin
        if (!REQ1) begin
          state_d = REQ0 ? S_OWN0 : S_IDLE;
          last_d  = REQ0 ? 1'b0 : last_q;
          cnt_d   = 4'd0;
        end else if (w_ack1) begin
          if (w_lock) begin
            cnt_d = w_at_limit ? C_HOLD[3:0] : w_cnt_inc[3:0];
          end else if (w_at_limit) begin
            cnt_d = 4'd0;
            if (REQ0) begin
              state_d = S_OWN0;
              last_d  = 1'b0;
            end
          end else begin
            cnt_d = w_cnt_inc[3:0];
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    w_slot_free = ~dvalid_q | DREADY;
    w_ack0      = state_q[0] & REQ0 & w_slot_free;
    w_ack1      = state_q[1] & REQ1 & w_slot_free;
    dout_d      = dout_q;
    dvalid_d    = dvalid_q;
    if (w_ack0) begin
      dout_d   = DIN0;
      dvalid_d = 1'b1;
    end else if (w_ack1) begin
      dout_d   = DIN1;
      dvalid_d = 1'b1;
    end else if (DREADY) begin
      dvalid_d = 1'b0;
    end
  end

  assign GNT0   = state_q[0];
  assign GNT1   = state_q[1];
  assign SEL    = state_q[1];
  assign ACK0   = w_ack0;
  assign ACK1   = w_ack1;
  assign DOUT   = dout_q;
  assign DVALID = dvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_mux2_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux2_share_arbiter
// Purpose  : Vector table plus scoreboarded byte streams for mux2_share_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux2_share_arbiter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       REQ0, REQ1, DREADY;
  logic [7:0] DIN0, DIN1;
  logic       GNT0, GNT1, ACK0, ACK1, SEL, DVALID;
  logic [7:0] DOUT;
`ifdef MUX2_ARB_LOCK_EN
  logic       LOCK;
`endif

  always #5 CLK = ~CLK;

  mux2_share_arbiter #(.WIDTH(8), .HOLD_MAX(4)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .REQ0   (REQ0),
    .DIN0   (DIN0),
    .REQ1   (REQ1),
    .DIN1   (DIN1),
`ifdef MUX2_ARB_LOCK_EN
    .LOCK   (LOCK),
`endif
    .DREADY (DREADY),
    .GNT0   (GNT0),
    .GNT1   (GNT1),
    .ACK0   (ACK0),
    .ACK1   (ACK1),
    .SEL    (SEL),
    .DOUT   (DOUT),
    .DVALID (DVALID)
  );

  // exp_ctl = {GNT0, GNT1, ACK0, ACK1, SEL, DVALID}
  typedef struct {
    logic       req0;
    logic [7:0] din0;
    logic       req1;
    logic [7:0] din1;
    logic       dready;
    logic [5:0] exp_ctl;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t       tbl[15];
  logic [7:0] sb[$];
  logic [7:0] b0[32];
  logic [7:0] b1[32];
  int         n_vec = 0;
  int         n_err = 0;
  int         idx0, idx1, bubbles, g0_cycles;
  bit         a0, a1, done;

  function automatic vec_t mk(input logic r0, input logic [7:0] d0, input logic r1,
                              input logic [7:0] d1, input logic rdy,
                              input logic [5:0] ctl, input logic [7:0] dout);
    vec_t v;
    v.req0 = r0; v.din0 = d0; v.req1 = r1; v.din1 = d1; v.dready = rdy;
    v.exp_ctl = ctl; v.exp_dout = dout;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_src(input bit rnd, input int n0, input int n1, input int lock_beats);
    REQ0   = (idx0 < n0);
    DIN0   = (idx0 < n0) ? b0[idx0] : 8'h00;
    REQ1   = (idx1 < n1);
    DIN1   = (idx1 < n1) ? b1[idx1] : 8'h00;
    DREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
`ifdef MUX2_ARB_LOCK_EN
    LOCK   = (idx0 < lock_beats);
`else
    if (lock_beats < 0) DREADY = 1'b1;
`endif
  endtask

  // Producers advance on ACK; every accepted output byte is checked against sb.
  task automatic run_stream(input int n0, input int n1, input bit rnd, input int lock_beats);
    logic [7:0] exp;
    idx0 = 0; idx1 = 0; bubbles = 0; g0_cycles = 0; done = 0;
    drive_src(rnd, n0, n1, lock_beats);
    for (int cyc = 0; cyc < 500 && !done; cyc++) begin
      @(negedge CLK);
      a0 = ACK0;
      a1 = ACK1;
      if ((REQ0 || REQ1) && !GNT0 && !GNT1) bubbles++;
      if (GNT0) g0_cycles++;
      if (DVALID && DREADY) begin
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL stream extra byte: got %h expected none", DOUT);
        end else begin
          exp = sb.pop_front();
          chk("stream dout", {24'd0, DOUT}, {24'd0, exp});
        end
      end
      @(posedge CLK); #1;
      if (a0) idx0++;
      if (a1) idx1++;
      drive_src(rnd, n0, n1, lock_beats);
      done = (idx0 >= n0) && (idx1 >= n1) && (sb.size() == 0);
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL stream timeout: got idx0=%0d idx1=%0d left=%0d expected all drained",
               idx0, idx1, sb.size());
      sb.delete();
    end
    DREADY = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; REQ0 = 0; REQ1 = 0; DIN0 = 0; DIN1 = 0; DREADY = 1'b1;
`ifdef MUX2_ARB_LOCK_EN
    LOCK = 1'b0;
`endif
    tbl[0]  = mk(0, 8'h00, 0, 8'h00, 1, 6'b000000, 8'h00);
    tbl[1]  = mk(1, 8'hA5, 0, 8'h00, 1, 6'b000000, 8'h00);
    tbl[2]  = mk(1, 8'hA5, 0, 8'h00, 1, 6'b101000, 8'h00);
    for (int i = 3; i < 8; i++) tbl[i] = mk(1, 8'h3C, 0, 8'h00, 0, 6'b100001, 8'hA5);
    tbl[8]  = mk(1, 8'h3C, 0, 8'h00, 1, 6'b101001, 8'hA5);
    tbl[9]  = mk(0, 8'h00, 0, 8'h00, 1, 6'b100001, 8'h3C);
    tbl[10] = mk(0, 8'h00, 0, 8'h00, 1, 6'b000000, 8'h3C);
    tbl[11] = mk(1, 8'h11, 1, 8'h22, 1, 6'b000000, 8'h3C);
    tbl[12] = mk(1, 8'h11, 1, 8'h22, 1, 6'b010110, 8'h3C);
    tbl[13] = mk(0, 8'h11, 0, 8'h22, 1, 6'b010011, 8'h22);
    tbl[14] = mk(0, 8'h00, 0, 8'h00, 1, 6'b000000, 8'h22);

    repeat (2) @(negedge CLK);
    chk("reset state", {18'd0, GNT0, GNT1, ACK0, ACK1, SEL, DVALID, DOUT}, 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;

    for (int i = 0; i < 15; i++) begin
      REQ0 = tbl[i].req0; DIN0 = tbl[i].din0;
      REQ1 = tbl[i].req1; DIN1 = tbl[i].din1;
      DREADY = tbl[i].dready;
      @(negedge CLK);
      chk($sformatf("vector %0d", i),
          {18'd0, GNT0, GNT1, ACK0, ACK1, SEL, DVALID, DOUT},
          {18'd0, tbl[i].exp_ctl, tbl[i].exp_dout});
      @(posedge CLK); #1;
    end

    // Requester 1 alone for 10 beats: grant never leaves it.
    for (int k = 0; k < 10; k++) begin b1[k] = 8'hC0 + 8'(k); sb.push_back(b1[k]); end
    run_stream(0, 10, 1'b0, 0);
    chk("solo gnt0 cycles", g0_cycles, 0);
    chk("solo idle bubbles", bubbles, 1);

    // Tie with LAST=1: requester 0 first, then 4-beat alternation under random back-pressure.
    for (int k = 0; k < 8; k++) begin b0[k] = 8'h10 + 8'(k); b1[k] = 8'h20 + 8'(k); end
    for (int k = 0; k < 4; k++) sb.push_back(b0[k]);
    for (int k = 0; k < 4; k++) sb.push_back(b1[k]);
    for (int k = 4; k < 8; k++) sb.push_back(b0[k]);
    for (int k = 4; k < 8; k++) sb.push_back(b1[k]);
    run_stream(8, 8, 1'b1, 0);
    chk("tie idle bubbles", bubbles, 1);

    // Asynchronous reset mid-cycle while OWN1 holds an unconsumed byte.
    REQ0 = 0; REQ1 = 0; DREADY = 1'b1;
    @(posedge CLK); #1;
    REQ1 = 1'b1; DIN1 = 8'h77; DREADY = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("pre-reset own1", {22'd0, GNT1, DVALID, DOUT}, {22'd0, 1'b1, 1'b1, 8'h77});
    #2 RESET = 1'b1;
    #1 chk("async reset", {21'd0, GNT0, GNT1, SEL, DVALID, DOUT}, 32'd0);
    #1 RESET = 1'b0;
    REQ0 = 1'b1; DIN0 = 8'h5A; REQ1 = 1'b1; DIN1 = 8'h77; DREADY = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("post-reset tie", {28'd0, GNT0, GNT1, ACK0, SEL}, {28'd0, 4'b1010});
    @(posedge CLK); #1;
    REQ0 = 0; REQ1 = 0;
    repeat (2) @(posedge CLK);
    #1;

`ifdef MUX2_ARB_LOCK_EN
    // LOCK keeps requester 0 for 8 beats; rotation happens on the first ACK after it drops.
    RESET = 1'b1;
    #2 RESET = 1'b0;
    @(posedge CLK); #1;
    for (int k = 0; k < 12; k++) b0[k] = 8'h40 + 8'(k);
    for (int k = 0; k < 4; k++) b1[k] = 8'h60 + 8'(k);
    for (int k = 0; k < 9; k++) sb.push_back(b0[k]);
    for (int k = 0; k < 4; k++) sb.push_back(b1[k]);
    for (int k = 9; k < 12; k++) sb.push_back(b0[k]);
    run_stream(12, 4, 1'b0, 8);
    chk("lock idle bubbles", bubbles, 1);
    LOCK = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
